// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one external combinational ALU
// between two valid/ready requesters. Ops are serialized: accept -> issue
// -> response, with operands latched and the result registered with a zero flag.
`timescale 1ns/1ps
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    // shared ALU
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    // response 0
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    // response 1
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_gsel;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_grant_vld;
    logic             w_grant_idx;
    logic             w_idle;
    logic             w_accept;
    logic             w_resp_hs;

    // Round-robin grant: a lone requester wins, a tie goes away from last_grant.
    always_comb begin
        w_grant_vld = req0_valid | req1_valid;
        w_grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_idx = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_idx = 1'b1;
        end
    end

    // Ready is masked while rst is high so reset drives every output low.
    assign w_idle     = (r_state == IDLE) && !rst;
    assign w_accept   = w_idle && w_grant_vld;
    assign req0_ready = w_accept && !w_grant_idx;
    assign req1_ready = w_accept &&  w_grant_idx;
    assign w_resp_hs  = (r_state == RESP) && (r_gsel ? resp1_ready : resp0_ready);

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = ISSUE;
            ISSUE:                  w_state_nxt = RESP;
            RESP:    if (w_resp_hs) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch on accept, result/zero capture at the end of ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gsel   <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gsel <= w_grant_idx;
                r_op   <= w_grant_idx ? req1_op : req0_op;
                r_a    <= w_grant_idx ? req1_a  : req0_a;
                r_b    <= w_grant_idx ? req1_b  : req0_b;
            end
            if (r_state == ISSUE) begin
                r_result <= alu_result;
                r_zero   <= ~|alu_result;
            end
        end
    end

    // Fairness pointer advances only when a response is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_resp_hs) begin
            r_last_grant <= r_gsel;
        end
    end

    assign alu_op       = r_op;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign resp0_valid  = (r_state == RESP) && !r_gsel;
    assign resp1_valid  = (r_state == RESP) &&  r_gsel;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp0_zero   = r_zero;
    assign resp1_zero   = r_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: scoreboard of expected responses pushed on
// accept and popped on response handshake, plus directed checks.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OPW-1:0]   req0_op, req1_op, alu_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             resp0_valid, resp0_ready, resp0_zero;
    logic             resp1_valid, resp1_ready, resp1_zero;
    logic [WIDTH-1:0] resp0_result, resp1_result;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero)
    );

    // External ALU model: 2 add, 3 sub, 4 xor, otherwise and.
    function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            OPW'(2): return a + b;
            OPW'(3): return a - b;
            OPW'(4): return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic             owner;
        logic [WIDTH-1:0] result;
        logic             zero;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic prev_rv = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            prev_rv = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                e.owner  = 1'b0;
                e.result = alu_f(req0_op, req0_a, req0_b);
                e.zero   = (e.result == '0);
                exp_q.push_back(e);
                grant_log.push_back(0);
                acc_cyc = cyc;
            end
            if (req1_valid && req1_ready) begin
                e.owner  = 1'b1;
                e.result = alu_f(req1_op, req1_a, req1_b);
                e.zero   = (e.result == '0);
                exp_q.push_back(e);
                grant_log.push_back(1);
                acc_cyc = cyc;
            end
            if (resp0_valid && resp1_valid) check("resp_both_valid", 64'd1, 64'd0);
            if ((resp0_valid || resp1_valid) && !prev_rv)
                check("resp_latency", 64'(cyc - acc_cyc), 64'd2);
            prev_rv = resp0_valid || resp1_valid;
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_owner", 64'(resp1_valid), 64'(e.owner));
                    check("resp_result", 64'(resp1_valid ? resp1_result : resp0_result), 64'(e.result));
                    check("resp_zero", 64'(resp1_valid ? resp1_zero : resp0_zero), 64'(e.zero));
                end
            end
        end
    end

    task automatic drive_set(input int k, input logic v, input logic [OPW-1:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (k == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Waits for requester k to be accepted; returns 1ns after the accept edge.
    task automatic wait_accept(input int k);
        int n = 0;
        @(negedge clk);
        while (!((k == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check($sformatf("accept_timeout_req%0d", k), 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    // Waits until every expected response has been consumed and the FSM is back in IDLE.
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("drain_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int k, input logic [OPW-1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        drive_set(k, 1'b1, op, a, b);
        wait_accept(k);
        drive_set(k, 1'b0, '0, '0, '0);
        wait_drain();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req0_ready"},  64'(req0_ready),   64'd0);
        check({tag, "_req1_ready"},  64'(req1_ready),   64'd0);
        check({tag, "_resp0_valid"}, 64'(resp0_valid),  64'd0);
        check({tag, "_resp1_valid"}, 64'(resp1_valid),  64'd0);
        check({tag, "_alu_op"},      64'(alu_op),       64'd0);
        check({tag, "_alu_a"},       64'(alu_a),        64'd0);
        check({tag, "_alu_b"},       64'(alu_b),        64'd0);
        check({tag, "_result"},      64'(resp0_result), 64'd0);
        check({tag, "_zero"},        64'(resp0_zero | resp1_zero), 64'd0);
    endtask

    // Holds rst across a full cycle (including a negedge) and releases it 1ns after a posedge.
    task automatic release_reset();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_no_resp(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(tag, 64'(resp0_valid | resp1_valid), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int g0;
        logic [WIDTH-1:0] held;

        rst = 1'b1;
        drive_set(0, 1'b0, '0, '0, '0);
        drive_set(1, 1'b0, '0, '0, '0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #12;
        check_reset_outs("por");
        release_reset();

        // Single op from requester 0: 5 + 7.
        drive_set(0, 1'b1, OPW'(2), 32'd5, 32'd7);
        wait_accept(0);
        drive_set(0, 1'b0, '0, '0, '0);
        check("issue_alu_op", 64'(alu_op), 64'd2);
        check("issue_alu_a",  64'(alu_a),  64'd5);
        check("issue_alu_b",  64'(alu_b),  64'd7);
        @(negedge clk);
        @(posedge clk); #1;
        check("s1_resp0_valid",  64'(resp0_valid),  64'd1);
        check("s1_resp1_valid",  64'(resp1_valid),  64'd0);
        check("s1_resp0_result", 64'(resp0_result), 64'd12);
        check("s1_resp0_zero",   64'(resp0_zero),   64'd0);
        wait_drain();

        // Zero flag, including a result that is zero except for the MSB.
        do_op(1, OPW'(3), 32'd9, 32'd9);
        do_op(1, OPW'(3), 32'h8000_0000, 32'd0);
        do_op(0, OPW'(4), 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Contention from the first cycle after reset: strict alternation from req0.
        rst = 1'b1;
        #1;
        release_reset();
        g0 = grant_log.size();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    drive_set(0, 1'b1, OPW'(2), WIDTH'(100 + i), WIDTH'(i));
                    wait_accept(0);
                end
                drive_set(0, 1'b0, '0, '0, '0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    drive_set(1, 1'b1, OPW'(3), WIDTH'(200 + i), WIDTH'(7 * i));
                    wait_accept(1);
                end
                drive_set(1, 1'b0, '0, '0, '0);
            end
        join
        wait_drain();
        check("contend_count", 64'(grant_log.size() - g0), 64'd8);
        if (grant_log.size() - g0 == 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("contend_grant_%0d", i), 64'(grant_log[g0 + i]), 64'(i % 2));
        end

        // Response backpressure on requester 0 while requester 1 waits.
        g0 = grant_log.size();
        resp0_ready = 1'b0;
        drive_set(0, 1'b1, OPW'(2), 32'd10, 32'd20);
        wait_accept(0);
        drive_set(0, 1'b0, '0, '0, '0);
        drive_set(1, 1'b1, OPW'(4), 32'h0000_F0F0, 32'h0000_0FF0);
        @(negedge clk);
        @(posedge clk); #1;
        held = resp0_result;
        check("bp_result", 64'(held), 64'd30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp0_valid", 64'(resp0_valid), 64'd1);
            check("bp_stable", 64'(resp0_result), 64'(held));
            check("bp_req1_ready", 64'(req1_ready), 64'd0);
        end
        @(posedge clk); #1;
        resp0_ready = 1'b1;
        drive_set(0, 1'b1, OPW'(2), 32'd1, 32'd1);
        wait_accept(1);
        drive_set(1, 1'b0, '0, '0, '0);
        wait_accept(0);
        drive_set(0, 1'b0, '0, '0, '0);
        wait_drain();
        check("bp_count", 64'(grant_log.size() - g0), 64'd3);
        if (grant_log.size() - g0 == 3) begin
            check("bp_grant_0", 64'(grant_log[g0]),     64'd0);
            check("bp_grant_1", 64'(grant_log[g0 + 1]), 64'd1);
            check("bp_grant_2", 64'(grant_log[g0 + 2]), 64'd0);
        end

        // Reset during ISSUE: last completed op was req0, so only reset makes the tie go to req0.
        do_op(0, OPW'(2), 32'd1, 32'd2);
        drive_set(1, 1'b1, OPW'(2), 32'd3, 32'd4);
        wait_accept(1);
        drive_set(1, 1'b0, '0, '0, '0);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_issue");
        release_reset();
        check_no_resp("rst_issue_no_resp", 4);
        drive_set(0, 1'b1, OPW'(2), 32'd11, 32'd22);
        drive_set(1, 1'b1, OPW'(2), 32'd33, 32'd44);
        @(negedge clk);
        check("rst_issue_tie_req0", 64'(req0_ready), 64'd1);
        check("rst_issue_tie_req1", 64'(req1_ready), 64'd0);
        @(posedge clk); #1;
        drive_set(0, 1'b0, '0, '0, '0);
        drive_set(1, 1'b0, '0, '0, '0);
        wait_drain();

        // Reset during RESP with the response held back.
        resp1_ready = 1'b0;
        drive_set(1, 1'b1, OPW'(2), 32'd5, 32'd6);
        wait_accept(1);
        drive_set(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(posedge clk); #1;
        check("rst_resp_pre_valid", 64'(resp1_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_resp");
        resp1_ready = 1'b1;
        release_reset();
        check_no_resp("rst_resp_no_resp", 4);
        drive_set(0, 1'b1, OPW'(2), 32'd7, 32'd8);
        drive_set(1, 1'b1, OPW'(2), 32'd9, 32'd10);
        @(negedge clk);
        check("rst_resp_tie_req0", 64'(req0_ready), 64'd1);
        check("rst_resp_tie_req1", 64'(req1_ready), 64'd0);
        @(posedge clk); #1;
        drive_set(0, 1'b0, '0, '0, '0);
        drive_set(1, 1'b0, '0, '0, '0);
        wait_drain();

        // Requester 1 withdraws a one-cycle request issued while the FSM is in RESP.
        g0 = grant_log.size();
        resp0_ready = 1'b0;
        drive_set(0, 1'b1, OPW'(3), 32'd50, 32'd8);
        wait_accept(0);
        drive_set(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(posedge clk); #1;
        drive_set(1, 1'b1, OPW'(2), 32'd77, 32'd1);
        @(negedge clk);
        check("wd_req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk); #1;
        drive_set(1, 1'b0, '0, '0, '0);
        resp0_ready = 1'b1;
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wd_no_resp1", 64'(resp1_valid), 64'd0);
        end
        check("wd_grants", 64'(grant_log.size() - g0), 64'd1);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
